// File: rtl/rbm_iteration_controller.sv
// rbm_iteration_controller
//
// Sequencing FSM for the RBM inference datapath. One accepted input vector
// launches iteration_num Gibbs passes. Each pass issues
// hidden_adder_group_num hidden-layer jobs, then cl_adder_group_num
// classifier jobs. Each job uses a start/done handshake. After the last pass
// the output register is strobed and finish is held until data_valid drops.
//
// Handshake semantics (all engine handshakes):
//   *_start is a one-cycle Moore strobe decoded from the registered state.
//   The matching *_done is sampled only in the following WAIT state and
//   must arrive no earlier than the first WAIT cycle. A *_done seen in any
//   other state is ignored, including in the cycle that carries the start
//   strobe. data_valid is level-sensitive and is sampled only in IDLE
//   (to launch a run) and in DONE (to release the result).
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   asynchronous active-high reset, forces IDLE
//   data_valid   in   input vector present and stable
//   input_latch  out  strobe: capture input vector (LOAD)
//   h_start      out  strobe: hidden engine starts job h_group (H_ISSUE)
//   h_group      out  current hidden adder group index
//   h_done       in   hidden engine finished current job (pulse)
//   c_start      out  strobe: classifier starts job c_group (C_ISSUE)
//   c_group      out  current classifier adder group index
//   c_done       in   classifier finished current job (pulse)
//   iter_idx     out  current Gibbs pass index
//   output_latch out  strobe: load classifier result (OUT)
//   busy         out  high in every state except IDLE and DONE
//   finish       out  result valid, held high in DONE
//   state_dbg    out  registered FSM state, for observation only
module rbm_iteration_controller #(
  parameter int hidden_adder_group_num = 1,
  parameter int cl_adder_group_num     = 1,
  parameter int iteration_num          = 1,
  parameter int hg_width = (hidden_adder_group_num > 1) ? $clog2(hidden_adder_group_num) : 1,
  parameter int cg_width = (cl_adder_group_num > 1) ? $clog2(cl_adder_group_num) : 1,
  parameter int it_width = (iteration_num > 1) ? $clog2(iteration_num) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                data_valid,
  output logic                input_latch,
  output logic                h_start,
  output logic [hg_width-1:0] h_group,
  input  logic                h_done,
  output logic                c_start,
  output logic [cg_width-1:0] c_group,
  input  logic                c_done,
  output logic [it_width-1:0] iter_idx,
  output logic                output_latch,
  output logic                busy,
  output logic                finish,
  output logic [2:0]          state_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD    = 3'd1;
  localparam logic [2:0] H_ISSUE = 3'd2;
  localparam logic [2:0] H_WAIT  = 3'd3;
  localparam logic [2:0] C_ISSUE = 3'd4;
  localparam logic [2:0] C_WAIT  = 3'd5;
  localparam logic [2:0] OUT     = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;

  // Last valid index of each counter; counters stop here and never wrap.
  localparam logic [hg_width-1:0] H_LAST = hg_width'(hidden_adder_group_num - 1);
  localparam logic [cg_width-1:0] C_LAST = cg_width'(cl_adder_group_num - 1);
  localparam logic [it_width-1:0] I_LAST = it_width'(iteration_num - 1);

  logic [2:0] state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      h_group  <= '0;
      c_group  <= '0;
      iter_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) state <= LOAD;
        end
        LOAD: begin
          h_group  <= '0;
          c_group  <= '0;
          iter_idx <= '0;
          state    <= H_ISSUE;
        end
        H_ISSUE: state <= H_WAIT;
        H_WAIT: begin
          if (h_done) begin
            if (h_group == H_LAST) begin
              c_group <= '0;
              state   <= C_ISSUE;
            end else begin
              h_group <= h_group + 1'b1;
              state   <= H_ISSUE;
            end
          end
        end
        C_ISSUE: state <= C_WAIT;
        C_WAIT: begin
          if (c_done) begin
            if (c_group < C_LAST) begin
              c_group <= c_group + 1'b1;
              state   <= C_ISSUE;
            end else if (iter_idx < I_LAST) begin
              // Next Gibbs pass restarts the hidden layer from group 0.
              iter_idx <= iter_idx + 1'b1;
              h_group  <= '0;
              state    <= H_ISSUE;
            end else begin
              state <= OUT;
            end
          end
        end
        OUT: state <= DONE;
        // Leaving DONE needs data_valid low, so a held data_valid cannot
        // relaunch a second run on the same vector.
        DONE: begin
          if (!data_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decodes of the registered state; an asynchronous reset clears
  // them at once because state itself is cleared asynchronously.
  assign input_latch  = (state == LOAD);
  assign h_start      = (state == H_ISSUE);
  assign c_start      = (state == C_ISSUE);
  assign output_latch = (state == OUT);
  assign finish       = (state == DONE);
  assign busy         = (state != IDLE) && (state != DONE);
  assign state_dbg    = state;

endmodule

// File: tb/tb_rbm_iteration_controller.sv
// Bench for rbm_iteration_controller. Two instances: a 3/2/2 configuration
// and the minimal 1/1/1 one. The bench plays both compute engines and
// predicts every output cycle by cycle from a job list and the latencies it
// chose itself.
module tb_rbm_iteration_controller;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // ---------------- shared stimulus, routed to the selected DUT ----------------
  logic dv, h_done, c_done, sel;

  logic b_dv, b_hd, b_cd, b_il, b_hs, b_cs, b_ol, b_busy, b_fin;
  logic [1:0] b_hg;
  logic [0:0] b_cg, b_it;
  logic [2:0] b_st;

  logic m_dv, m_hd, m_cd, m_il, m_hs, m_cs, m_ol, m_busy, m_fin;
  logic [0:0] m_hg, m_cg, m_it;
  logic [2:0] m_st;

  assign b_dv = sel ? 1'b0 : dv;
  assign b_hd = sel ? 1'b0 : h_done;
  assign b_cd = sel ? 1'b0 : c_done;
  assign m_dv = sel ? dv : 1'b0;
  assign m_hd = sel ? h_done : 1'b0;
  assign m_cd = sel ? c_done : 1'b0;

  logic o_il, o_hs, o_cs, o_ol, o_busy, o_fin;
  logic [1:0] o_hg;
  logic [0:0] o_cg, o_it;
  assign o_il   = sel ? m_il   : b_il;
  assign o_hs   = sel ? m_hs   : b_hs;
  assign o_cs   = sel ? m_cs   : b_cs;
  assign o_ol   = sel ? m_ol   : b_ol;
  assign o_busy = sel ? m_busy : b_busy;
  assign o_fin  = sel ? m_fin  : b_fin;
  assign o_hg   = sel ? {1'b0, m_hg} : b_hg;
  assign o_cg   = sel ? m_cg : b_cg;
  assign o_it   = sel ? m_it : b_it;

  rbm_iteration_controller #(
    .hidden_adder_group_num(3),
    .cl_adder_group_num(2),
    .iteration_num(2)
  ) u_dut (
    .clock(clock), .reset(reset), .data_valid(b_dv),
    .input_latch(b_il), .h_start(b_hs), .h_group(b_hg), .h_done(b_hd),
    .c_start(b_cs), .c_group(b_cg), .c_done(b_cd), .iter_idx(b_it),
    .output_latch(b_ol), .busy(b_busy), .finish(b_fin), .state_dbg(b_st)
  );

  rbm_iteration_controller #(
    .hidden_adder_group_num(1),
    .cl_adder_group_num(1),
    .iteration_num(1)
  ) u_min (
    .clock(clock), .reset(reset), .data_valid(m_dv),
    .input_latch(m_il), .h_start(m_hs), .h_group(m_hg), .h_done(m_hd),
    .c_start(m_cs), .c_group(m_cg), .c_done(m_cd), .iter_idx(m_it),
    .output_latch(m_ol), .busy(m_busy), .finish(m_fin), .state_dbg(m_st)
  );

  // ---------------- scoreboard ----------------
  // Expected job order: {type[1:0] (1=hidden, 2=classifier, 3=output), group[2:0], pass[2:0]}
  logic [7:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic check_zero(input string tag, input bit with_groups);
    check_eq({tag, ".input_latch"}, 32'(o_il), 0);
    check_eq({tag, ".h_start"}, 32'(o_hs), 0);
    check_eq({tag, ".c_start"}, 32'(o_cs), 0);
    check_eq({tag, ".output_latch"}, 32'(o_ol), 0);
    check_eq({tag, ".busy"}, 32'(o_busy), 0);
    check_eq({tag, ".finish"}, 32'(o_fin), 0);
    if (with_groups) begin
      check_eq({tag, ".h_group"}, 32'(o_hg), 0);
      check_eq({tag, ".c_group"}, 32'(o_cg), 0);
      check_eq({tag, ".iter_idx"}, 32'(o_it), 0);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Idle with data_valid low and random stray done pulses.
  task automatic idle_cycles(input int n, input bit with_groups);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      dv     = 1'b0;
      h_done = ($urandom_range(0, 2) == 0);
      c_done = ($urandom_range(0, 2) == 0);
      @(negedge clock);
      check_zero("idle", with_groups);
    end
    h_done = 1'b0;
    c_done = 1'b0;
  endtask

  // One run. data_valid rises in cycle 0. Engines answer after 1..max_lat
  // wait cycles; stray dones are injected whenever an engine is not being
  // waited on. drop_early lowers data_valid during the first hidden wait;
  // otherwise it is held hold_after cycles past the first finish cycle.
  // abort_c>0 asserts reset mid-cycle while waiting on that classifier job.
  task automatic run_one(input bit use_min, input int hg, input int cg, input int it,
                         input int max_lat, input bit drop_early, input int hold_after,
                         input int abort_c);
    int next_issue, fin_start, dv_off, h_cnt, c_cnt, c_issued, lat, last_fin;
    bit finished, aborted, issue_now, in_hwait, in_cwait;
    logic [7:0] front;
    logic [1:0] ftype;
    sel = use_min;
    exp_q.delete();
    for (int p = 0; p < it; p++) begin
      for (int g = 0; g < hg; g++) exp_q.push_back({2'd1, 3'(g), 3'(p)});
      for (int g = 0; g < cg; g++) exp_q.push_back({2'd2, 3'(g), 3'(p)});
    end
    exp_q.push_back({2'd3, 6'd0});
    next_issue = 2;  // LOAD in cycle 1, first hidden issue in cycle 2
    fin_start = -1; dv_off = -1; h_cnt = 0; c_cnt = 0; c_issued = 0;
    finished = 1'b0; aborted = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished && !aborted; cyc++) begin
      @(posedge clock); #1;
      if (cyc == 0) dv = 1'b1;
      in_hwait = (h_cnt > 0);
      in_cwait = (c_cnt > 0);
      if (in_hwait) begin h_cnt--; h_done = (h_cnt == 0); end
      else h_done = ($urandom_range(0, 3) == 0);
      if (in_cwait) begin c_cnt--; c_done = (c_cnt == 0); end
      else c_done = ($urandom_range(0, 3) == 0);
      if (dv && drop_early && in_hwait) begin dv = 1'b0; dv_off = cyc; end
      if (dv && fin_start >= 0 && cyc >= fin_start + hold_after) begin dv = 1'b0; dv_off = cyc; end
      if (abort_c > 0 && c_issued == abort_c && in_cwait) begin
        #2;
        reset = 1'b1; dv = 1'b0; h_done = 1'b0; c_done = 1'b0;
        #1;
        check_zero("mid_run_reset", 1'b1);
        @(negedge clock);
        reset = 1'b0;
        aborted = 1'b1;
      end else begin
        @(negedge clock);
        issue_now = (exp_q.size() > 0) && (cyc == next_issue);
        front = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        ftype = front[7:6];
        last_fin = (dv_off > fin_start) ? dv_off : fin_start;
        check_eq("input_latch", 32'(o_il), 32'(cyc == 1));
        check_eq("h_start", 32'(o_hs), 32'(issue_now && ftype == 2'd1));
        check_eq("c_start", 32'(o_cs), 32'(issue_now && ftype == 2'd2));
        check_eq("output_latch", 32'(o_ol), 32'(issue_now && ftype == 2'd3));
        check_eq("busy", 32'(o_busy), 32'(cyc >= 1 && (fin_start < 0 || cyc < fin_start)));
        check_eq("finish", 32'(o_fin),
                 32'(fin_start >= 0 && cyc >= fin_start && (dv_off < 0 || cyc <= last_fin)));
        if (issue_now) begin
          lat = $urandom_range(1, max_lat);
          case (ftype)
            2'd1: begin
              check_eq("h_group", 32'(o_hg), 32'(front[5:3]));
              check_eq("h_iter", 32'(o_it), 32'(front[2:0]));
              h_cnt = lat;
              next_issue += 1 + lat;
            end
            2'd2: begin
              check_eq("c_group", 32'(o_cg), 32'(front[5:3]));
              check_eq("c_iter", 32'(o_it), 32'(front[2:0]));
              c_cnt = lat;
              c_issued++;
              next_issue += 1 + lat;
            end
            default: begin
              check_eq("out_h_group", 32'(o_hg), hg - 1);
              check_eq("out_c_group", 32'(o_cg), cg - 1);
              check_eq("out_iter", 32'(o_it), it - 1);
              fin_start = cyc + 1;
            end
          endcase
          void'(exp_q.pop_front());
        end
        if (fin_start >= 0 && dv_off >= 0 && cyc >= last_fin + 3) finished = 1'b1;
      end
    end
    if (abort_c > 0) check_eq("abort_reached", 32'(aborted), 1);
    else check_eq("run_complete", 32'(finished), 1);
    dv = 1'b0; h_done = 1'b0; c_done = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    sel = 1'b0; dv = 1'b0; h_done = 1'b0; c_done = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_zero("reset_init", 1'b1);
    reset = 1'b0;

    // asynchronous reset while idle, then a quiet idle window
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    check_zero("async_reset_idle", 1'b1);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(20, 1'b1);

    // minimal configuration, engines answer after one wait cycle
    run_one(1'b1, 1, 1, 1, 1, 1'b0, 3, 0);
    idle_cycles(3, 1'b0);

    // multi-group, multi-pass with random latencies
    for (int r = 0; r < 6; r++) run_one(1'b0, 3, 2, 2, 5, 1'b0, $urandom_range(0, 3), 0);

    // data_valid dropped while waiting on the hidden engine
    run_one(1'b0, 3, 2, 2, 5, 1'b1, 0, 0);
    run_one(1'b1, 1, 1, 1, 3, 1'b1, 0, 0);

    // reset while waiting on the first classifier job of pass 1
    run_one(1'b0, 3, 2, 2, 5, 1'b0, 1, 3);
    idle_cycles(20, 1'b1);
    run_one(1'b0, 3, 2, 2, 5, 1'b0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rbm_iteration_controller.md
# rbm_iteration_controller

Sequencing FSM for the RBM inference datapath between the top-level input handshake (`data_valid` / `finish`) and the two compute engines: the hidden layer and the classifier layer. It accepts one input vector, then runs `iteration_num` Gibbs passes. Each pass runs `hidden_adder_group_num` hidden-layer adder-group jobs, then `cl_adder_group_num` classifier jobs, each job using a start/done handshake. It then strobes the output register and raises `finish`.

## Interface

Parameters:
- `hidden_adder_group_num`, default 1: hidden-layer jobs per pass; must be ≥1.
- `cl_adder_group_num`, default 1: classifier jobs per pass; must be ≥1.
- `iteration_num`, default 1: Gibbs passes per input; must be ≥1.
- `hg_width`, default max(1, clog2(hidden_adder_group_num)): width of `h_group`.
- `cg_width`, default max(1, clog2(cl_adder_group_num)): width of `c_group`.
- `it_width`, default max(1, clog2(iteration_num)): width of `iter_idx`.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `data_valid`  in  1  input vector present and stable; level-sensitive.
- `input_latch`  out  1  one-cycle strobe: capture the input vector into the datapath.
- `h_start`  out  1  one-cycle strobe: hidden engine starts job `h_group`.
- `h_group`  out  hg_width  index of the current hidden adder group.
- `h_done`  in  1  hidden engine finished the current job; single-cycle pulse.
- `c_start`  out  1  one-cycle strobe: classifier starts job `c_group`.
- `c_group`  out  cg_width  index of the current classifier adder group.
- `c_done`  in  1  classifier finished the current job; single-cycle pulse.
- `iter_idx`  out  it_width  index of the current pass.
- `output_latch`  out  1  one-cycle strobe: load the classifier result into the output register.
- `busy`  out  1  high in every state except IDLE and DONE.
- `finish`  out  1  result valid; held high in DONE.

## Operation

- States: IDLE, LOAD, H_ISSUE, H_WAIT, C_ISSUE, C_WAIT, OUT, DONE.
- All strobes are Moore outputs decoded from the registered state, so they are glitch-free:
  - `input_latch` = LOAD
  - `h_start` = H_ISSUE
  - `c_start` = C_ISSUE
  - `output_latch` = OUT
  - `finish` = DONE
- IDLE: if `data_valid`=1, go to LOAD; otherwise stay.
- LOAD: clear `h_group`, `c_group`, `iter_idx`; go to H_ISSUE.
- H_ISSUE: go to H_WAIT.
- H_WAIT: stay until `h_done`=1. Then:
  - if `h_group` = hidden_adder_group_num-1: clear `c_group`, go to C_ISSUE;
  - else increment `h_group`, go to H_ISSUE.
- C_ISSUE: go to C_WAIT.
- C_WAIT: stay until `c_done`=1. Then:
  - if `c_group` < cl_adder_group_num-1: increment `c_group`, go to C_ISSUE;
  - else if `iter_idx` < iteration_num-1: increment `iter_idx`, clear `h_group`, go to H_ISSUE;
  - else go to OUT.
- OUT: go to DONE.
- DONE: hold `finish`=1 while `data_valid`=1. When `data_valid`=0, go to IDLE. This gives no auto-restart on a held `data_valid`.
- Ignored inputs:
  - `h_done` outside H_WAIT and `c_done` outside C_WAIT;
  - `data_valid` falling mid-run (the run completes; DONE then lasts exactly one cycle);
  - `h_done` and `c_done` asserted in the same cycle (only the one matching the current WAIT state counts).
- Group and iteration counters never wrap. Each counter stops at its maximum and is cleared only by LOAD, by the transitions above, or by reset.

## Timing

- Reset, asynchronous:
  - state=IDLE;
  - `h_group`=`c_group`=`iter_idx`=0;
  - all strobes, `busy` and `finish` = 0 immediately, without waiting for a clock edge.
- Deassertion of reset is synchronous to `clock`. Reset mid-run drops any strobe or `finish` at once; the next run needs `data_valid` sampled high in IDLE.
- Edge numbering: E0 is the edge that samples `data_valid`=1 in IDLE.
  - LOAD follows E0 (E1); H_ISSUE follows E1 (E2).
- Lh is the number of H_WAIT cycles before `h_done`, minimum 1; Lc is the same for C_WAIT and `c_done`.
  - Each hidden job costs 1+Lh cycles; each classifier job costs 1+Lc cycles.
- OUT is entered at E2 + iteration_num·(HG·(1+Lh) + CG·(1+Lc)), where HG = hidden_adder_group_num and CG = cl_adder_group_num.
- `finish` rises one edge after OUT.
- Minimum case (all parameters 1, Lh=Lc=1): OUT after E6, `finish` high after E7.
- `h_done` arriving in the same cycle as `h_start` (H_ISSUE) is ignored; the engine must respond in H_WAIT. The same rule applies to `c_done` and C_ISSUE.

## Test plan

- Reset/idle:
  - stimulus: assert `reset` asynchronously mid-cycle, with `data_valid`=0;
  - required: all outputs 0 before the next edge; state stays IDLE with no strobes for 20 cycles.
- Minimal run:
  - stimulus: parameters 1/1/1, `data_valid` held 1, engines return done 1 cycle after start;
  - required: `input_latch`@E1, `h_start`@E2, `c_start`@E4, `output_latch`@E6, `finish` rises after E7 and stays high until `data_valid`=0, then IDLE the next cycle.
- Multi-group, multi-pass:
  - stimulus: HG=3, CG=2, IT=2, random done latency 1–5;
  - required: `h_group` sequence 0,1,2 followed by `c_group` 0,1, repeated twice with `iter_idx` 0 then 1; exactly 6 `h_start`, 4 `c_start`, 1 `output_latch`.
- Spurious done:
  - stimulus: `h_done` pulsed during IDLE, C_WAIT and H_ISSUE; `c_done` pulsed during H_WAIT;
  - required: no state advance, counters unchanged.
- Reset mid-run:
  - stimulus: assert `reset` during C_WAIT with IT=2;
  - required: immediate IDLE with all outputs 0; a new run starts from `h_group`=`iter_idx`=0.
- Early `data_valid` drop:
  - stimulus: deassert `data_valid` during H_WAIT;
  - required: the run completes, `finish` is high for exactly 1 cycle, then IDLE.
